irrigation_sequencer: RTL
=========================

Name: irrigation_sequencer

Overview:
- Clocked controller that sequences the irrigation datapath: inlet valve Ve, drip valve Vs, sprinkler valve Bs and alarm Al.
- Replaces the purely combinational valve equations with synchronised and debounced sensors, minimum on-times and break-before-make valve switching.
- Adds fill-timeout supervision and a latched fault state.
- Sits between the raw tank-level/soil/temperature sensors and the valve drivers.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive equal synchronised samples required before a sensor's debounced value changes
MIN_ON_CYCLES, 16, minimum cycles DRIP or SPRAY is held once entered (safety exits excepted)
SETTLE_CYCLES, 2, cycles with Vs=Bs=0 between any two irrigation states
FILL_TIMEOUT, 64, max cycles Ve may stay open without the level code rising

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
H  in  1  tank high sensor (raw)
M  in  1  tank mid sensor (raw)
L  in  1  tank low sensor (raw)
Us  in  1  soil wet sensor (raw)
Ua  in  1  soil damp sensor (raw)
T  in  1  high-temperature sensor (raw)
FaultClr  in  1  fault acknowledge, level-sampled
Ve  out  1  inlet valve open
Vs  out  1  drip valve open
Bs  out  1  sprinkler valve open
Al  out  1  alarm
Fault  out  1  fault latched
State  out  3  FSM state: 0 IDLE, 1 SETTLE, 2 DRIP, 3 SPRAY, 4 FAULT

Behaviour:
- One clock. Reset is asynchronous and active-low. While rst_n=0: Ve=Vs=Bs=Al=Fault=0, State=IDLE, all counters 0, debounced values 0. Reset mid-irrigation closes every valve immediately, without waiting for a clock edge.
- Input path per sensor: 2-flop synchroniser, then a debounce counter. The debounced value takes the synchronised value on the edge where DEBOUNCE_CYCLES consecutive equal samples complete. Any differing sample restarts the count.
- All outputs are registered. Raw input edge -> output change takes exactly DEBOUNCE_CYCLES+3 clk edges.
- Level decode uses debounced {H,M,L}:
  - Vazio=000, Baixo=001, Medio=011, Cheio=111.
  - Erro=(M&~L)|(H&~M).
  - Level code 0..3 follows the same order.
- Demand decode:
  - Us=1 -> none.
  - Us=0,Ua=0 -> SPRAY.
  - Us=0,Ua=1,(T|Baixo) -> DRIP.
  - Us=0,Ua=1,~T,Medio/Cheio -> SPRAY.
- Water OK = ~Vazio & ~Erro.
- FSM:
  - IDLE: if Erro -> FAULT; else if demand!=none and water OK -> SETTLE.
  - SETTLE: Vs=Bs=0 for SETTLE_CYCLES, then -> the demanded state. If demand is none or water is not OK, -> IDLE. Erro -> FAULT.
  - DRIP/SPRAY: the matching valve is 1, the other is 0.
    - Erro -> FAULT, and Vazio -> IDLE, both immediately regardless of the on-timer.
    - After MIN_ON_CYCLES, demand change -> SETTLE (if the new demand is not none) or -> IDLE (if none).
  - FAULT: Vs=Bs=Ve=0, Fault=1. Exit to IDLE only when FaultClr=1 and Erro=0; otherwise hold.
- Vs&Bs=1 is never permitted in any cycle.
- Inlet valve, evaluated outside FAULT:
  - Opens at Vazio or Baixo, closes at Cheio, holds its value at Medio, forced 0 on Erro.
  - Fill counter runs while Ve=1 and clears when the level code increases or Ve=0.
  - Counter reaching FILL_TIMEOUT -> FAULT (sticky, same exit rule).
- Al=Fault|Vazio|Baixo, registered.
- Simultaneous events: priority order is Erro > fill timeout > Vazio > demand change.

Optional Feature:
- Macro MANUAL_OVERRIDE_EN.
- Defined: adds inputs Man (1) and ManSpray (1). When Man=1, demand is forced to SPRAY if ManSpray=1, else DRIP, ignoring the Us/Ua/T decode. Erro, Vazio, FAULT, settle and min-on rules still apply. Man is synchronised and debounced like the other sensors.
- Undefined: ports absent; demand comes from the sensors only.

Test Plan:
1. Reset with H=M=L=1, Us=0, Ua=0 -> all outputs 0. After rst_n rises: State 0->1 at edge 7, Bs=1 at edge 9 (State=3), Ve=0, Al=0.
2. Glitch: in SPRAY, pulse Ua=1 for 3 cycles -> no change in state or outputs.
3. SPRAY entered, then Us=1 after 5 cycles -> Bs stays 1 until 16 cycles in SPRAY, then Bs=0, State=IDLE. Vs never 1.
4. DRIP active, set {H,M,L}=000 -> Vs=0 and State=IDLE 7 edges later, ignoring min-on. Ve=1, Al=1.
5. Hold {H,M,L}=001 with Ve open for 64 cycles -> Fault=1, State=4, Ve=0. FaultClr=1 -> IDLE next edge.
6. Set {H,M,L}=010 during SPRAY -> Bs=0, State=4, Al=1. FaultClr=1 while still 010 -> stays FAULT.

Source files
------------

// File: rtl/irrigation_sequencer.sv
`default_nettype none
// ============================================================================
// Module     : irrigation_sequencer
// Description: Clocked valve sequencer for the irrigation tank. It debounces
//              the sensors, holds minimum on-times, switches the valves
//              break-before-make and latches faults. The optional manual
//              override is built when MANUAL_OVERRIDE_EN is defined.
// Revision   : 1.0 - initial release
// ============================================================================
module irrigation_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MIN_ON_CYCLES   = 16,
    parameter int SETTLE_CYCLES   = 2,
    parameter int FILL_TIMEOUT    = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       H,
    input  logic       M,
    input  logic       L,
    input  logic       Us,
    input  logic       Ua,
    input  logic       T,
`ifdef MANUAL_OVERRIDE_EN
    input  logic       Man,
    input  logic       ManSpray,
`endif
    input  logic       FaultClr,
    output logic       Ve,
    output logic       Vs,
    output logic       Bs,
    output logic       Al,
    output logic       Fault,
    output logic [2:0] State
);

`ifdef MANUAL_OVERRIDE_EN
    localparam int c_NUM_SENS = 8;
`else
    localparam int c_NUM_SENS = 6;
`endif
    localparam int c_DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_ON_W   = $clog2(MIN_ON_CYCLES + 1);
    localparam int c_SET_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int c_FILL_W = $clog2(FILL_TIMEOUT + 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_SETTLE = 3'd1;
    localparam logic [2:0] c_DRIP   = 3'd2;
    localparam logic [2:0] c_SPRAY  = 3'd3;
    localparam logic [2:0] c_FAULT  = 3'd4;

    localparam logic [1:0] c_D_NONE  = 2'd0;
    localparam logic [1:0] c_D_DRIP  = 2'd1;
    localparam logic [1:0] c_D_SPRAY = 2'd2;

    logic [c_NUM_SENS-1:0] w_raw;
    logic [c_NUM_SENS-1:0] w_deb;

`ifdef MANUAL_OVERRIDE_EN
    assign w_raw = {ManSpray, Man, T, Ua, Us, L, M, H};
`else
    assign w_raw = {T, Ua, Us, L, M, H};
`endif

    // Debounced value follows the synchroniser only after a full run of
    // differing samples; any sample equal to the current value restarts it.
    for (genvar gi = 0; gi < c_NUM_SENS; gi++) begin : g_sens
        logic              r_meta;
        logic              r_sync;
        logic              r_deb;
        logic [c_DB_W-1:0] r_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_meta <= 1'b0;
                r_sync <= 1'b0;
                r_deb  <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_meta <= w_raw[gi];
                r_sync <= r_meta;
                if (r_sync == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_deb <= r_sync;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_DB_W'(1);
                end
            end
        end

        assign w_deb[gi] = r_deb;
    end

    logic w_h, w_m, w_l, w_us, w_ua, w_t;
    assign w_h  = w_deb[0];
    assign w_m  = w_deb[1];
    assign w_l  = w_deb[2];
    assign w_us = w_deb[3];
    assign w_ua = w_deb[4];
    assign w_t  = w_deb[5];

    logic w_vazio, w_baixo, w_medio, w_cheio, w_erro, w_waterOk;
    assign w_vazio   = ~w_h & ~w_m & ~w_l;
    assign w_baixo   = ~w_h & ~w_m &  w_l;
    assign w_medio   = ~w_h &  w_m &  w_l;
    assign w_cheio   =  w_h &  w_m &  w_l;
    assign w_erro    = (w_m & ~w_l) | (w_h & ~w_m);
    assign w_waterOk = ~w_vazio & ~w_erro;

    logic [1:0] w_levelCode;
    assign w_levelCode = w_cheio ? 2'd3 : w_medio ? 2'd2 : w_baixo ? 2'd1 : 2'd0;

    logic [1:0] w_demand;
    always_comb begin
        w_demand = c_D_NONE;
`ifdef MANUAL_OVERRIDE_EN
        if (w_deb[6])
            w_demand = w_deb[7] ? c_D_SPRAY : c_D_DRIP;
        else
`endif
        if (!w_us) begin
            if (!w_ua)
                w_demand = c_D_SPRAY;
            else if (w_t | w_baixo)
                w_demand = c_D_DRIP;
            else
                w_demand = c_D_SPRAY;
        end
    end

    logic [2:0]          r_state;
    logic                r_ve, r_vs, r_bs, r_al, r_fault;
    logic [1:0]          r_prevLevel;
    logic [c_FILL_W-1:0] r_fillCnt;
    logic [c_SET_W-1:0]  r_settleCnt;
    logic [c_ON_W-1:0]   r_onCnt;

    logic w_levelUp, w_fillTimeout, w_minDone, w_settleDone;
    assign w_levelUp     = w_levelCode > r_prevLevel;
    assign w_fillTimeout = r_ve & ~w_levelUp & (r_fillCnt == c_FILL_W'(FILL_TIMEOUT - 1));
    assign w_minDone     = r_onCnt == c_ON_W'(MIN_ON_CYCLES - 1);
    assign w_settleDone  = r_settleCnt == c_SET_W'(SETTLE_CYCLES - 1);

    logic [2:0] w_next;
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_erro || w_fillTimeout)
                    w_next = c_FAULT;
                else if (w_demand != c_D_NONE && w_waterOk)
                    w_next = c_SETTLE;
            end
            c_SETTLE: begin
                if (w_erro || w_fillTimeout)
                    w_next = c_FAULT;
                else if (w_demand == c_D_NONE || !w_waterOk)
                    w_next = c_IDLE;
                else if (w_settleDone)
                    w_next = (w_demand == c_D_SPRAY) ? c_SPRAY : c_DRIP;
            end
            c_DRIP, c_SPRAY: begin
                if (w_erro || w_fillTimeout)
                    w_next = c_FAULT;
                else if (w_vazio)
                    w_next = c_IDLE;
                else if (w_minDone &&
                         w_demand != ((r_state == c_DRIP) ? c_D_DRIP : c_D_SPRAY))
                    w_next = (w_demand == c_D_NONE) ? c_IDLE : c_SETTLE;
            end
            c_FAULT: begin
                if (FaultClr && !w_erro)
                    w_next = c_IDLE;
            end
            default: w_next = c_IDLE;
        endcase
    end

    // Inlet hysteresis: open when low, close when full, keep value at mid.
    logic w_veNext;
    always_comb begin
        w_veNext = r_ve;
        if (w_next == c_FAULT || w_erro)
            w_veNext = 1'b0;
        else if (w_vazio || w_baixo)
            w_veNext = 1'b1;
        else if (w_cheio)
            w_veNext = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_ve        <= 1'b0;
            r_vs        <= 1'b0;
            r_bs        <= 1'b0;
            r_al        <= 1'b0;
            r_fault     <= 1'b0;
            r_prevLevel <= 2'd0;
            r_fillCnt   <= '0;
            r_settleCnt <= '0;
            r_onCnt     <= '0;
        end else begin
            r_state     <= w_next;
            r_vs        <= (w_next == c_DRIP);
            r_bs        <= (w_next == c_SPRAY);
            r_fault     <= (w_next == c_FAULT);
            r_al        <= (w_next == c_FAULT) | w_vazio | w_baixo;
            r_ve        <= w_veNext;
            r_prevLevel <= w_levelCode;

            if (!r_ve || w_levelUp || w_next == c_FAULT)
                r_fillCnt <= '0;
            else
                r_fillCnt <= r_fillCnt + c_FILL_W'(1);

            if (r_state == c_SETTLE && w_next == c_SETTLE)
                r_settleCnt <= r_settleCnt + c_SET_W'(1);
            else
                r_settleCnt <= '0;

            if (w_next == r_state && (r_state == c_DRIP || r_state == c_SPRAY)) begin
                if (!w_minDone)
                    r_onCnt <= r_onCnt + c_ON_W'(1);
            end else begin
                r_onCnt <= '0;
            end
        end
    end

    assign Ve    = r_ve;
    assign Vs    = r_vs;
    assign Bs    = r_bs;
    assign Al    = r_al;
    assign Fault = r_fault;
    assign State = r_state;

endmodule
`default_nettype wire
